commit_ctrl: RTL and testbench

COMMIT_CTRL -- requirements
Module: commit_ctrl

---
 rtl/commit_ctrl.sv | 167 ++++++++++++++++
 tb/tb_commit_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_ctrl.sv
// Commit stage controller: retires scoreboard head entries, sequences store commits
// and captures exceptions. Define COMMIT_INSTRET_CNT_EN to build the retired-instruction counter.
package commit_ctrl_pkg;
   localparam int unsigned NR_COMMIT_PORTS = 2;
   localparam int unsigned REG_ADDR_SIZE   = 5;

   typedef enum logic [2:0] {
      FU_NONE, FU_ALU, FU_MULT, FU_LOAD, FU_STORE, FU_BRANCH, FU_CSR, FU_FPU
   } fu_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic                     valid;
      fu_t                      fu;
      logic [7:0]               op;
      logic [REG_ADDR_SIZE-1:0] rd;
      logic [63:0]              result;
      exception_t               ex;
   } scoreboard_entry_t;

   // Opcodes with the top bit set produce a floating-point destination.
   function automatic logic is_rd_fpr(input logic [7:0] op);
      return op[7];
   endfunction
endpackage

// state   | meaning
// IDLE    | retiring head entries, issuing store commit requests
// ST_WAIT | store accepted by store buffer, waiting for completion
// EXC     | exception reported, commits blocked until flush
module commit_ctrl
   import commit_ctrl_pkg::*;
(
   input  logic                                            clk_i,
   input  logic                                            rst_ni,
   input  logic                                            halt_i,
   input  logic                                            flush_i,
   input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]         commit_instr_i,
   output logic [NR_COMMIT_PORTS-1:0]                      commit_ack_o,
   output logic [NR_COMMIT_PORTS-1:0][REG_ADDR_SIZE-1:0]   waddr_o,
   output logic [NR_COMMIT_PORTS-1:0][63:0]                wdata_o,
   output logic [NR_COMMIT_PORTS-1:0]                      we_gpr_o,
   output logic [NR_COMMIT_PORTS-1:0]                      we_fpr_o,
   output logic                                            commit_lsu_o,
   input  logic                                            commit_lsu_ready_i,
   input  logic                                            commit_lsu_done_i,
   output exception_t                                      exception_o,
   output logic [63:0]                                     instret_o
);
   typedef enum logic [1:0] {IDLE, ST_WAIT, EXC} state_t;

   state_t     r_state, w_state_nxt;
   exception_t r_exception;
   logic       w_exc_capture;
   logic [NR_COMMIT_PORTS-1:0] w_ack, w_we_gpr, w_we_fpr;
   logic       w_lsu;
   logic       w_unused;

   function automatic logic wr_fpr(input scoreboard_entry_t e);
      return (e.fu != FU_STORE) && (e.fu != FU_BRANCH) && is_rd_fpr(e.op);
   endfunction

   // A branch without rd has rd 0, so the rd check also covers it.
   function automatic logic wr_gpr(input scoreboard_entry_t e);
      return (e.fu != FU_STORE) && !wr_fpr(e) && (e.rd != '0);
   endfunction

   always_comb begin
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         waddr_o[i] = commit_instr_i[i].rd;
         wdata_o[i] = commit_instr_i[i].result;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ack         = '0;
      w_we_gpr      = '0;
      w_we_fpr      = '0;
      w_lsu         = 1'b0;
      w_exc_capture = 1'b0;
      case (r_state)
         IDLE: begin
            if (!flush_i && !halt_i && commit_instr_i[0].valid) begin
               if (commit_instr_i[0].ex.valid) begin
                  w_ack[0]      = 1'b1;
                  w_exc_capture = 1'b1;
                  w_state_nxt   = EXC;
               end else if (commit_instr_i[0].fu == FU_STORE) begin
                  w_lsu = 1'b1;
                  if (commit_lsu_ready_i) w_state_nxt = ST_WAIT;
               end else begin
                  w_ack[0]    = 1'b1;
                  w_we_gpr[0] = wr_gpr(commit_instr_i[0]);
                  w_we_fpr[0] = wr_fpr(commit_instr_i[0]);
                  if (commit_instr_i[1].valid && !commit_instr_i[1].ex.valid &&
                      (commit_instr_i[1].fu == FU_ALU || commit_instr_i[1].fu == FU_MULT)) begin
                     w_ack[1]    = 1'b1;
                     w_we_gpr[1] = wr_gpr(commit_instr_i[1]);
                     w_we_fpr[1] = wr_fpr(commit_instr_i[1]);
                  end
               end
            end
         end
         ST_WAIT: begin
            if (flush_i) begin
               w_state_nxt = IDLE;
            end else if (commit_lsu_done_i) begin
               w_ack[0]    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         EXC: begin
            if (flush_i) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are held low while reset is applied, independent of the inputs.
   assign commit_ack_o = rst_ni ? w_ack    : '0;
   assign we_gpr_o     = rst_ni ? w_we_gpr : '0;
   assign we_fpr_o     = rst_ni ? w_we_fpr : '0;
   assign commit_lsu_o = rst_ni & w_lsu;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_exception <= '0;
      end else if (w_exc_capture) begin
         r_exception       <= commit_instr_i[0].ex;
         r_exception.valid <= 1'b1;
      end else begin
         r_exception.valid <= 1'b0;
      end
   end

   assign exception_o = r_exception;

`ifdef COMMIT_INSTRET_CNT_EN
   logic [63:0] r_instret;
   logic [63:0] w_retired;

   // The excepting instruction is acked but does not retire.
   assign w_retired = {63'd0, w_ack[0] & ~w_exc_capture} + {63'd0, w_ack[1]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_instret <= '0;
      else         r_instret <= r_instret + w_retired;
   end

   assign instret_o = r_instret;
`else
   assign instret_o = '0;
`endif

   assign w_unused = ^{commit_instr_i[1].ex.cause, commit_instr_i[1].ex.tval};
endmodule

// File: tb/tb_commit_ctrl.sv
// Scoreboard bench for commit_ctrl: per-cycle expectations are queued when stimulus is driven
// and popped against the DUT outputs at the following falling edge.
module tb_commit_ctrl;
   import commit_ctrl_pkg::*;

`ifdef COMMIT_INSTRET_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic halt_i = 1'b0, flush_i = 1'b0;
   logic commit_lsu_ready_i = 1'b0, commit_lsu_done_i = 1'b0;
   scoreboard_entry_t [1:0] commit_instr_i;
   logic [1:0]        commit_ack_o, we_gpr_o, we_fpr_o;
   logic [1:0][4:0]   waddr_o;
   logic [1:0][63:0]  wdata_o;
   logic              commit_lsu_o;
   exception_t        exception_o;
   logic [63:0]       instret_o;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_instret = '0;
   logic [6:0]  exp_q[$];

   typedef struct {
      scoreboard_entry_t p0, p1;
      logic halt, flush, ready, done;
      logic [6:0] exp;   // {ack[1:0], we_gpr[1:0], we_fpr[1:0], lsu}
      logic exc;
   } step_t;

   commit_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .halt_i(halt_i), .flush_i(flush_i),
      .commit_instr_i(commit_instr_i), .commit_ack_o(commit_ack_o),
      .waddr_o(waddr_o), .wdata_o(wdata_o), .we_gpr_o(we_gpr_o), .we_fpr_o(we_fpr_o),
      .commit_lsu_o(commit_lsu_o), .commit_lsu_ready_i(commit_lsu_ready_i),
      .commit_lsu_done_i(commit_lsu_done_i), .exception_o(exception_o), .instret_o(instret_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic scoreboard_entry_t ent(input fu_t fu, input logic [7:0] op,
                                             input logic [4:0] rd, input logic [63:0] res);
      scoreboard_entry_t e;
      e = '0;
      e.valid = 1'b1; e.fu = fu; e.op = op; e.rd = rd; e.result = res;
      return e;
   endfunction

   function automatic scoreboard_entry_t exc_ent(input logic [63:0] cause);
      scoreboard_entry_t e;
      e = ent(FU_ALU, 8'h01, 5'd9, 64'hdead);
      e.ex.valid = 1'b1; e.ex.cause = cause; e.ex.tval = 64'h1234;
      return e;
   endfunction

   function automatic step_t mk(input scoreboard_entry_t p0, p1, input logic halt, flush,
                                ready, done, input logic [6:0] exp, input logic exc);
      step_t s;
      s.p0 = p0; s.p1 = p1; s.halt = halt; s.flush = flush;
      s.ready = ready; s.done = done; s.exp = exp; s.exc = exc;
      return s;
   endfunction

   task automatic drive_step(input step_t s);
      @(posedge clk_i); #1;
      commit_instr_i[0] = s.p0; commit_instr_i[1] = s.p1;
      halt_i = s.halt; flush_i = s.flush;
      commit_lsu_ready_i = s.ready; commit_lsu_done_i = s.done;
      exp_q.push_back(s.exp);
      if (CNT_EN) exp_instret = exp_instret + 64'(s.exp[6]) + 64'(s.exp[5]) - 64'(s.exc);
   endtask

   scoreboard_entry_t NONE;
   initial NONE = '0;

   task automatic test_reset();
      logic [6:0] obs;
      commit_instr_i[0] = ent(FU_ALU, 8'h01, 5'd1, 64'h11);
      commit_instr_i[1] = ent(FU_ALU, 8'h01, 5'd2, 64'h22);
      commit_lsu_ready_i = 1'b1;
      @(negedge clk_i);
      obs = {commit_ack_o, we_gpr_o, we_fpr_o, commit_lsu_o};
      checks++;
      if (obs !== 7'd0) begin failures++; $display("FAIL reset_outputs got=%b expected=%b", obs, 7'd0); end
      checks++;
      if (exception_o !== '0) begin failures++; $display("FAIL reset_exception got=%h expected=0", exception_o); end
      checks++;
      if (instret_o !== 64'd0) begin failures++; $display("FAIL reset_instret got=%0d expected=0", instret_o); end
      @(posedge clk_i); #1;
      commit_instr_i = '0; commit_lsu_ready_i = 1'b0;
      rst_ni = 1'b1;
   endtask

   task automatic test_write_enables();
      step_t s[$];
      logic [6:0] got, obs;
      scoreboard_entry_t p1x;
      p1x = ent(FU_ALU, 8'h01, 5'd4, 64'h44);
      p1x.ex.valid = 1'b1;
      s.push_back(mk(ent(FU_ALU, 8'h01, 5'd5, 64'h55), ent(FU_ALU, 8'h01, 5'd6, 64'h66), 0, 0, 0, 0, 7'b11_11_00_0, 0));
      s.push_back(mk(ent(FU_ALU, 8'h01, 5'd7, 64'hAAAA), ent(FU_MULT, 8'h02, 5'd7, 64'hBBBB), 0, 0, 0, 0, 7'b11_11_00_0, 0));
      s.push_back(mk(ent(FU_ALU, 8'h01, 5'd0, 64'h1), ent(FU_ALU, 8'h01, 5'd0, 64'h2), 0, 0, 0, 0, 7'b11_00_00_0, 0));
      s.push_back(mk(ent(FU_FPU, 8'h81, 5'd0, 64'h3), ent(FU_MULT, 8'h02, 5'd3, 64'h4), 0, 0, 0, 0, 7'b11_10_01_0, 0));
      s.push_back(mk(ent(FU_ALU, 8'h01, 5'd1, 64'h5), ent(FU_STORE, 8'h03, 5'd0, 64'h6), 0, 0, 0, 0, 7'b01_01_00_0, 0));
      s.push_back(mk(ent(FU_ALU, 8'h01, 5'd1, 64'h5), ent(FU_LOAD, 8'h04, 5'd2, 64'h7), 0, 0, 0, 0, 7'b01_01_00_0, 0));
      s.push_back(mk(ent(FU_BRANCH, 8'h05, 5'd0, 64'h8), ent(FU_ALU, 8'h01, 5'd2, 64'h9), 0, 0, 0, 0, 7'b11_10_00_0, 0));
      s.push_back(mk(ent(FU_ALU, 8'h01, 5'd1, 64'h5), p1x, 0, 0, 0, 0, 7'b01_01_00_0, 0));
      s.push_back(mk(NONE, ent(FU_ALU, 8'h01, 5'd2, 64'h9), 0, 0, 0, 0, 7'b00_00_00_0, 0));
      s.push_back(mk(NONE, NONE, 0, 0, 0, 0, 7'd0, 0));
      foreach (s[i]) begin
         drive_step(s[i]);
         @(negedge clk_i);
         got = exp_q.pop_front();
         obs = {commit_ack_o, we_gpr_o, we_fpr_o, commit_lsu_o};
         checks++;
         if (obs !== got) begin failures++; $display("FAIL write_enables step %0d ack/gpr/fpr/lsu got=%b expected=%b", i, obs, got); end
         if (i == 0) begin
            checks++;
            if (waddr_o !== {5'd6, 5'd5}) begin failures++; $display("FAIL dual_waddr got=%h expected=%h", waddr_o, {5'd6, 5'd5}); end
         end
         if (i == 1) begin
            checks++;
            if (wdata_o[1] !== 64'hBBBB) begin failures++; $display("FAIL same_rd_wdata1 got=%h expected=%h", wdata_o[1], 64'hBBBB); end
         end
      end
      checks++;
      if (instret_o !== exp_instret) begin failures++; $display("FAIL instret_after_writes got=%0d expected=%0d", instret_o, exp_instret); end
   endtask

   task automatic test_store();
      step_t s[$];
      logic [6:0] got, obs;
      scoreboard_entry_t st;
      st = ent(FU_STORE, 8'h03, 5'd0, 64'h77);
      s.push_back(mk(st, NONE, 0, 0, 1, 0, 7'b00_00_00_1, 0));
      s.push_back(mk(st, NONE, 0, 0, 0, 0, 7'd0, 0));
      s.push_back(mk(st, NONE, 0, 0, 1, 0, 7'd0, 0));
      s.push_back(mk(st, NONE, 1, 0, 0, 1, 7'b01_00_00_0, 0));
      s.push_back(mk(ent(FU_ALU, 8'h01, 5'd4, 64'h4), NONE, 0, 0, 0, 0, 7'b01_01_00_0, 0));
      s.push_back(mk(st, NONE, 0, 0, 0, 0, 7'b00_00_00_1, 0));
      s.push_back(mk(st, NONE, 0, 0, 0, 1, 7'b00_00_00_1, 0));
      s.push_back(mk(st, NONE, 0, 0, 1, 0, 7'b00_00_00_1, 0));
      s.push_back(mk(NONE, NONE, 0, 1, 0, 1, 7'd0, 0));
      s.push_back(mk(NONE, NONE, 0, 0, 0, 1, 7'd0, 0));
      s.push_back(mk(ent(FU_ALU, 8'h01, 5'd4, 64'h4), NONE, 0, 0, 0, 0, 7'b01_01_00_0, 0));
      foreach (s[i]) begin
         drive_step(s[i]);
         @(negedge clk_i);
         got = exp_q.pop_front();
         obs = {commit_ack_o, we_gpr_o, we_fpr_o, commit_lsu_o};
         checks++;
         if (obs !== got) begin failures++; $display("FAIL store step %0d ack/gpr/fpr/lsu got=%b expected=%b", i, obs, got); end
      end
   endtask

   task automatic test_exception();
      step_t s[$];
      logic [6:0] got, obs;
      scoreboard_entry_t a, b;
      a = ent(FU_ALU, 8'h01, 5'd8, 64'h8);
      b = ent(FU_ALU, 8'h01, 5'd9, 64'h9);
      s.push_back(mk(exc_ent(64'd2), a, 0, 0, 0, 0, 7'b01_00_00_0, 1));
      s.push_back(mk(a, b, 0, 0, 0, 0, 7'd0, 0));
      s.push_back(mk(a, b, 0, 0, 1, 0, 7'd0, 0));
      s.push_back(mk(a, b, 0, 1, 0, 0, 7'd0, 0));
      s.push_back(mk(a, b, 0, 0, 0, 0, 7'b11_11_00_0, 0));
      s.push_back(mk(NONE, NONE, 0, 0, 0, 0, 7'd0, 0));
      foreach (s[i]) begin
         drive_step(s[i]);
         @(negedge clk_i);
         got = exp_q.pop_front();
         obs = {commit_ack_o, we_gpr_o, we_fpr_o, commit_lsu_o};
         checks++;
         if (obs !== got) begin failures++; $display("FAIL exception step %0d ack/gpr/fpr/lsu got=%b expected=%b", i, obs, got); end
         if (i <= 2) begin
            checks++;
            if (exception_o.valid !== (i == 1)) begin
               failures++; $display("FAIL exc_valid step %0d got=%b expected=%b", i, exception_o.valid, (i == 1));
            end
         end
         if (i == 1 || i == 2) begin
            checks++;
            if (exception_o.cause !== 64'd2) begin failures++; $display("FAIL exc_cause step %0d got=%0d expected=2", i, exception_o.cause); end
         end
      end
      checks++;
      if (instret_o !== exp_instret) begin failures++; $display("FAIL instret_after_exc got=%0d expected=%0d", instret_o, exp_instret); end
   endtask

   task automatic test_halt_invalid();
      step_t s[$];
      logic [6:0] got, obs;
      scoreboard_entry_t st;
      st = ent(FU_STORE, 8'h03, 5'd0, 64'h77);
      s.push_back(mk(ent(FU_ALU, 8'h01, 5'd3, 64'h3), ent(FU_ALU, 8'h01, 5'd4, 64'h4), 1, 0, 0, 0, 7'd0, 0));
      s.push_back(mk(st, NONE, 1, 0, 1, 0, 7'd0, 0));
      s.push_back(mk(exc_ent(64'd5), NONE, 1, 0, 0, 0, 7'd0, 0));
      s.push_back(mk(NONE, ent(FU_ALU, 8'h01, 5'd4, 64'h4), 0, 0, 0, 0, 7'd0, 0));
      s.push_back(mk(st, NONE, 0, 0, 1, 0, 7'b00_00_00_1, 0));
      s.push_back(mk(st, NONE, 1, 0, 0, 1, 7'b01_00_00_0, 0));
      s.push_back(mk(NONE, NONE, 0, 0, 0, 0, 7'd0, 0));
      foreach (s[i]) begin
         drive_step(s[i]);
         @(negedge clk_i);
         got = exp_q.pop_front();
         obs = {commit_ack_o, we_gpr_o, we_fpr_o, commit_lsu_o};
         checks++;
         if (obs !== got) begin failures++; $display("FAIL halt step %0d ack/gpr/fpr/lsu got=%b expected=%b", i, obs, got); end
      end
   endtask

   task automatic test_reset_in_wait();
      step_t s[$];
      logic [6:0] got, obs;
      s.push_back(mk(ent(FU_STORE, 8'h03, 5'd0, 64'h77), NONE, 0, 0, 1, 0, 7'b00_00_00_1, 0));
      s.push_back(mk(NONE, NONE, 0, 0, 0, 1, 7'd0, 0));
      s.push_back(mk(NONE, NONE, 0, 0, 0, 1, 7'd0, 0));
      drive_step(s[0]);
      @(negedge clk_i);
      got = exp_q.pop_front();
      obs = {commit_ack_o, we_gpr_o, we_fpr_o, commit_lsu_o};
      checks++;
      if (obs !== got) begin failures++; $display("FAIL rst_wait_req got=%b expected=%b", obs, got); end
      @(posedge clk_i); #1;
      rst_ni = 1'b0; exp_instret = '0;
      commit_instr_i[0] = ent(FU_ALU, 8'h01, 5'd3, 64'h3);
      commit_lsu_done_i = 1'b1;
      @(negedge clk_i);
      obs = {commit_ack_o, we_gpr_o, we_fpr_o, commit_lsu_o};
      checks++;
      if (obs !== 7'd0) begin failures++; $display("FAIL rst_wait_during got=%b expected=%b", obs, 7'd0); end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      for (int i = 1; i < 3; i++) begin
         drive_step(s[i]);
         @(negedge clk_i);
         got = exp_q.pop_front();
         obs = {commit_ack_o, we_gpr_o, we_fpr_o, commit_lsu_o};
         checks++;
         if (obs !== got) begin failures++; $display("FAIL rst_wait step %0d got=%b expected=%b", i, obs, got); end
      end
      checks++;
      if (instret_o !== exp_instret) begin failures++; $display("FAIL instret_after_reset got=%0d expected=%0d", instret_o, exp_instret); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      commit_instr_i = '0;
      test_reset();
      test_write_enables();
      test_store();
      test_exception();
      test_halt_invalid();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
